// File: rtl/cmd_stream_writer.sv
// ---------------------------------------------------------------------------
// cmd_stream_writer
//
// Packs a stream of commands into a linear command memory.  Each command is
// a header word followed by cmd_nargs 32-bit argument words, written one
// word per cycle through a registered write port.  Addresses grow from 0 and
// never wrap; a command is only accepted if all of its words still fit.
// Commands with an illegal argument count are consumed without writing
// anything and raise the sticky err flag.
//
// State table:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for a command header (cmd_ready may be high)
//   S_ARGS | header written, collecting rem_args argument words
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (highest priority)
//   clear      in   synchronous flush of position, err and counters
//   cmd_valid  in   command header offered
//   cmd_ready  out  header accepted when cmd_valid also high
//   cmd_op     in   16-bit opcode, header bits [15:0]
//   cmd_nargs  in   number of argument words following the header
//   arg_valid  in   argument word offered
//   arg_ready  out  argument accepted when arg_valid also high
//   arg_data   in   32-bit argument word
//   mem_we     out  registered write strobe to command memory
//   mem_addr   out  registered write address
//   mem_wdata  out  registered write data
//   wr_count   out  words written since reset/clear
//   cmd_count  out  commands fully written since reset/clear (wraps)
//   full       out  wr_count == DEPTH
//   err        out  sticky illegal-argument-count flag
// ---------------------------------------------------------------------------
module cmd_stream_writer #(
    parameter int ADDR_W   = 6,
    parameter int MAX_ARGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_op,
    input  logic [4:0]        cmd_nargs,
    input  logic              arg_valid,
    output logic              arg_ready,
    input  logic [31:0]       arg_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic [15:0]       cmd_count,
    output logic              full,
    output logic              err
);

    // DEPTH expressed at the width of wr_count
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    // Space arithmetic width: wide enough for DEPTH and for nargs+1 (up to 32)
    localparam int CW = (ADDR_W + 2 > 7) ? ADDR_W + 2 : 7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARGS = 1'b1
    } state_t;

    state_t        state;
    logic [4:0]    rem_args;

    logic [CW-1:0] space_left;
    logic [CW-1:0] words_needed;
    logic          nargs_bad;
    logic          has_room;
    logic          cmd_hs;
    logic          arg_hs;
    logic [31:0]   header;

    assign nargs_bad    = ({27'd0, cmd_nargs} > MAX_ARGS);
    assign space_left   = CW'(DEPTH_W) - CW'(wr_count);
    assign words_needed = CW'(cmd_nargs) + CW'(1);
    assign has_room     = (space_left >= words_needed);

    // Illegal commands are always accepted (and dropped) so a bad producer
    // cannot wedge the stream, even when the memory is full.
    assign cmd_ready = !clear && (state == S_IDLE) && (nargs_bad || has_room);
    assign arg_ready = !clear && (state == S_ARGS);

    assign cmd_hs = cmd_valid && cmd_ready;
    assign arg_hs = arg_valid && arg_ready;

    // Bit 31 flags that argument words follow the header
    assign header = {(cmd_nargs != 5'd0), 15'd0, cmd_op};

    assign full = (wr_count == DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem_args  <= 5'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            wr_count  <= '0;
            cmd_count <= 16'd0;
            err       <= 1'b0;
        end else if (clear) begin
            // Abandons any partially written command; the memory port keeps
            // its last address/data but the strobe drops.
            state     <= S_IDLE;
            rem_args  <= 5'd0;
            mem_we    <= 1'b0;
            wr_count  <= '0;
            cmd_count <= 16'd0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        if (nargs_bad) begin
                            err <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_count[ADDR_W-1:0];
                            mem_wdata <= header;
                            wr_count  <= wr_count + 1'b1;
                            rem_args  <= cmd_nargs;
                            if (cmd_nargs == 5'd0) begin
                                cmd_count <= cmd_count + 16'd1;
                            end else begin
                                state <= S_ARGS;
                            end
                        end
                    end
                end

                S_ARGS: begin
                    if (arg_hs) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_count[ADDR_W-1:0];
                        mem_wdata <= arg_data;
                        wr_count  <= wr_count + 1'b1;
                        rem_args  <= rem_args - 5'd1;
                        // Terminal count: this handshake carries the last word
                        if (rem_args == 5'd1) begin
                            state     <= S_IDLE;
                            cmd_count <= cmd_count + 16'd1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
